alu_seq_legv8: RTL and testbench
================================

// Module: alu_seq_legv8
// PURPOSE
//  Parametrised, handshaked ALU for the LEGv8 datapath. Next generation of the combinational 64-bit ALU:
//  - width is a parameter
//  - operands and results move over valid/ready
//  - shifts are iterative and multi-cycle
//  - FS encoding and status flags are unchanged
// PARAMETERS
//  WIDTH       64  operand/result width; >= 8, power of 2. SHAMT_W = $clog2(WIDTH) (localparam).
//  SHIFT_STEP  1   bits shifted per BUSY cycle; power of 2, 1..WIDTH.
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high; clears all state
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept an operand beat
//  A          in   WIDTH    operand A
//  B          in   WIDTH    operand B; B[SHAMT_W-1:0] is the shift amount
//  FS         in   5        FS[0] Ainvert, FS[1] Binvert, FS[4:2] op select
//  CO         in   1        carry-in to ADD
//  out_valid  out  1        F/status valid
//  out_ready  in   1        consumer takes result
//  F          out  WIDTH    result
//  status     out  4        {V,C,N,Z}: status[3]=V, [2]=C, [1]=N, [0]=Z
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, F=0, status=0, counters=0.
//  Operand preparation:
//  - a' = FS[0] ? ~A : A; b' = FS[1] ? ~B : B.
//  - Shift amount is uninverted B[SHAMT_W-1:0].
//  FS[4:2] op select:
//  - 000 AND, 001 OR, 010 ADD (a'+b'+CO), 011 XOR
//  - 100 LSL a', 101 LSR a' (logical, zero fill)
//  - 110 MUL (only with macro), 111 undefined
//  - Undefined/disabled ops: F=0, status=0001 (Z=1), latency 1.
//  FSM states: IDLE, BUSY, DONE.
//  - in_ready = (state==IDLE). Accept when in_valid && in_ready; operands, FS and CO are latched.
//  - IDLE, accept, single-cycle op (AND/OR/ADD/XOR/undef): compute and register F/status; -> DONE.
//  - IDLE, accept, shift with amount 0: F=a'; -> DONE.
//  - IDLE, accept, shift with amount != 0: load F=a', cnt=amount; -> BUSY.
//  - BUSY: each cycle shift F by s=min(SHIFT_STEP,cnt), cnt-=s. When cnt reaches 0, register status; -> DONE.
//  - DONE: out_valid=1. F/status held stable until out_ready=1, then -> IDLE.
//  - in_valid is ignored outside IDLE; no input beat is lost, it waits for in_ready.
//  Latency (accept edge to out_valid high):
//  - single-cycle ops: 1 cycle
//  - shift: ceil(amount/SHIFT_STEP)+1 cycles
//  Throughput: at most one operation per 2 cycles (IDLE->DONE->IDLE).
//  Flags:
//  - Z = (F==0); N = F[WIDTH-1].
//  - ADD: C = carry out of bit WIDTH-1; V = (a'[MSB]==b'[MSB]) && (F[MSB]!=a'[MSB]).
//  - All other ops: C=0, V=0.
//  Arithmetic: modulo 2^WIDTH; the result never exceeds WIDTH bits.
//  Reset mid-operation (any state): immediately IDLE, out_valid=0, F=0, status=0; the pending op is discarded.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined:
//  - FS[4:2]=110 is an unsigned iterative shift-add multiply a'*b', low WIDTH bits.
//  - Runs WIDTH BUSY cycles (one multiplier bit per cycle); latency WIDTH+1.
//  - Flags: Z,N from F; C=V=0.
//  ALU_SEQ_MUL_EN undefined:
//  - 110 behaves as undefined (F=0, Z=1, latency 1).
//  - No multiplier or partial-product register is synthesised.
// TESTING (WIDTH=64, SHIFT_STEP=1 unless stated)
//  1. ADD: A=5, B=3, FS=01000, CO=0
//     -> out_valid 1 cycle after accept; F=8, status=0000.
//  2. SUB: A=3, B=5, FS=01010, CO=1
//     -> F=64'hFFFF_FFFF_FFFF_FFFE, status=0010 (N=1, C=0, V=0).
//  3. Overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, FS=01000, CO=0
//     -> F=64'h8000_0000_0000_0000, status=1010.
//  4. LSL: A=1, B=63, FS=10000
//     -> in_ready=0 for 64 cycles; out_valid at accept+64; F=64'h8000_0000_0000_0000, status=0010.
//     Repeat with SHIFT_STEP=8 -> out_valid at accept+9, same F.
//  5. Backpressure: complete test 1, hold out_ready=0 for 10 cycles while in_valid=1
//     -> F/status/out_valid stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
//  6. Reset mid-shift: assert reset 5 cycles into test 4
//     -> same cycle out_valid=0, F=0, status=0; after release in_ready=1 and test 1 passes.
//     With ALU_SEQ_MUL_EN: A=7, B=6, FS=11000 -> F=42 at accept+65.

Source files
------------

// File: rtl/alu_seq_legv8.sv
// Handshaked, width-parametrised LEGv8 ALU with iterative multi-cycle shifts.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add multiply on FS[4:2]=110.
module alu_seq_legv8 #(
  parameter int WIDTH      = 64,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             CO,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  localparam int SHAMT_W = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for the multiply
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
`endif

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [3:0]       status_q, status_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mca_q, mca_d;
  logic [WIDTH-1:0] mcb_q, mcb_d;
`endif

  logic [WIDTH-1:0]   a_p;
  logic [WIDTH-1:0]   b_p;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   step;

  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], (v == '0)};
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign F         = f_q;
  assign status    = status_q;

  always_comb begin
    a_p   = FS[0] ? ~A : A;
    b_p   = FS[1] ? ~B : B;
    shamt = B[SHAMT_W-1:0];
    sum   = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, CO};
    step  = (cnt_q < STEP_C) ? cnt_q : STEP_C;

    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    f_d      = f_q;
    status_d = status_q;
`ifdef ALU_SEQ_MUL_EN
    mca_d    = mca_q;
    mcb_d    = mcb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = FS[4:2];
          state_d = S_DONE;
          case (FS[4:2])
            OP_AND: begin
              f_d      = a_p & b_p;
              status_d = {2'b00, nz_of(f_d)};
            end
            OP_OR: begin
              f_d      = a_p | b_p;
              status_d = {2'b00, nz_of(f_d)};
            end
            OP_XOR: begin
              f_d      = a_p ^ b_p;
              status_d = {2'b00, nz_of(f_d)};
            end
            OP_ADD: begin
              f_d      = sum[WIDTH-1:0];
              status_d = {(a_p[WIDTH-1] == b_p[WIDTH-1]) && (f_d[WIDTH-1] != a_p[WIDTH-1]),
                          sum[WIDTH], nz_of(f_d)};
            end
            OP_LSL, OP_LSR: begin
              f_d = a_p;
              if (shamt == '0) begin
                status_d = {2'b00, nz_of(f_d)};
              end else begin
                cnt_d   = {1'b0, shamt};
                state_d = S_BUSY;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              f_d     = '0;
              mca_d   = a_p;
              mcb_d   = b_p;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_BUSY;
            end
`endif
            default: begin
              f_d      = '0;
              status_d = 4'b0001;
            end
          endcase
        end
      end
      S_BUSY: begin
        // The edge that drains the counter also publishes the result
        case (op_q)
          OP_LSL: begin
            f_d   = f_q << step;
            cnt_d = cnt_q - step;
          end
          OP_LSR: begin
            f_d   = f_q >> step;
            cnt_d = cnt_q - step;
          end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: begin
            f_d   = mcb_q[0] ? (f_q + mca_q) : f_q;
            mca_d = mca_q << 1;
            mcb_d = mcb_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
          end
`endif
          default: cnt_d = '0;
        endcase
        if (cnt_d == '0) begin
          status_d = {2'b00, nz_of(f_d)};
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      f_q      <= '0;
      status_q <= '0;
`ifdef ALU_SEQ_MUL_EN
      mca_q    <= '0;
      mcb_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      f_q      <= f_d;
      status_q <= status_d;
`ifdef ALU_SEQ_MUL_EN
      mca_q    <= mca_d;
      mcb_q    <= mcb_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_legv8.sv
// Directed self-checking bench for alu_seq_legv8 (WIDTH=64, SHIFT_STEP=1 and a SHIFT_STEP=8 copy).
module tb_alu_seq_legv8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_valid8;
  logic        in_ready, in_ready8;
  logic [63:0] A, B;
  logic [4:0]  FS;
  logic        CO;
  logic        out_valid, out_valid8;
  logic        out_ready;
  logic [63:0] F, F8;
  logic [3:0]  status, status8;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  alu_seq_legv8 #(.WIDTH(64), .SHIFT_STEP(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .CO(CO), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .status(status));

  alu_seq_legv8 #(.WIDTH(64), .SHIFT_STEP(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A), .B(B), .FS(FS), .CO(CO), .out_valid(out_valid8), .out_ready(out_ready),
    .F(F8), .status(status8));

  // Present one beat, then count edges (accept edge = 1) until out_valid rises
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                        input logic co, output int lat, output bit busy_low);
    A = a; B = b; FS = fs; CO = co; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_low = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] fs, input logic co, input logic [63:0] exp_f,
                          input logic [3:0] exp_s, input int exp_lat);
    int lat;
    bit busy_low;
    run_op(a, b, fs, co, lat, busy_low);
    tests_run++;
    if (lat !== exp_lat || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d (out_valid=%b), want %0d", name, lat, out_valid, exp_lat);
    end
    tests_run++;
    if (F !== exp_f) begin
      tests_failed++;
      $display("[TB] FAIL %s F: got %h, want %h", name, F, exp_f);
    end
    tests_run++;
    if (status !== exp_s) begin
      tests_failed++;
      $display("[TB] FAIL %s status: got %b, want %b", name, status, exp_s);
    end
    consume();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || F !== 64'd0 || status !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b F=%h st=%b, want 1 0 0 0",
               in_ready, out_valid, F, status);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_arith();
    check_op("add", 64'd5, 64'd3, 5'b01000, 1'b0, 64'd8, 4'b0000, 1);
    check_op("sub", 64'd3, 64'd5, 5'b01010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 1);
    check_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0,
             64'h8000_0000_0000_0000, 4'b1010, 1);
    check_op("carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'd0, 4'b0101, 1);
  endtask

  task automatic test_logic();
    check_op("and",  64'hF0, 64'h3C, 5'b00000, 1'b0, 64'h30, 4'b0000, 1);
    check_op("andz", 64'hF0, 64'h0F, 5'b00000, 1'b0, 64'h00, 4'b0001, 1);
    check_op("or",   64'hF0, 64'h3C, 5'b00100, 1'b0, 64'hFC, 4'b0000, 1);
    check_op("xor",  64'hF0, 64'h3C, 5'b01100, 1'b0, 64'hCC, 4'b0000, 1);
    check_op("nand", 64'hF0, 64'h3C, 5'b00111, 1'b0, 64'hFFFF_FFFF_FFFF_FFCF, 4'b0010, 1);
  endtask

  task automatic test_shift();
    int lat;
    bit busy_low;
    run_op(64'd1, 64'd63, 5'b10000, 1'b0, lat, busy_low);
    tests_run++;
    if (lat !== 64 || F !== 64'h8000_0000_0000_0000 || status !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL lsl63: got lat=%0d F=%h st=%b, want 64 8000000000000000 0010", lat, F, status);
    end
    tests_run++;
    if (busy_low !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lsl63_in_ready: got in_ready high while busy, want low");
    end
    consume();
    check_op("lsr4",  64'h8000_0000_0000_0000, 64'd4, 5'b10100, 1'b0,
             64'h0800_0000_0000_0000, 4'b0000, 5);
    check_op("lsr_hi_b", 64'hF0, 64'h43, 5'b10100, 1'b0, 64'h1E, 4'b0000, 4);
    check_op("lsl0",  64'h1234, 64'h40, 5'b10000, 1'b0, 64'h1234, 4'b0000, 1);
    check_op("lsl_ainv", 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'b10001, 1'b0, 64'd4, 4'b0000, 3);
  endtask

  task automatic test_shift_step8();
    int lat;
    A = 64'd1; B = 64'd63; FS = 5'b10000; CO = 1'b0; in_valid8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    tests_run++;
    if (lat !== 9 || F8 !== 64'h8000_0000_0000_0000 || status8 !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL lsl63_step8: got lat=%0d F=%h st=%b, want 9 8000000000000000 0010",
               lat, F8, status8);
    end
    consume();
  endtask

  task automatic test_undef();
    check_op("undef111", 64'd5, 64'd3, 5'b11100, 1'b0, 64'd0, 4'b0001, 1);
`ifdef ALU_SEQ_MUL_EN
    check_op("mul", 64'd7, 64'd6, 5'b11000, 1'b0, 64'd42, 4'b0000, 65);
`else
    check_op("mul_off", 64'd7, 64'd6, 5'b11000, 1'b0, 64'd0, 4'b0001, 1);
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    bit busy_low;
    bit stable;
    run_op(64'd5, 64'd3, 5'b01000, 1'b0, lat, busy_low);
    A = 64'd100; B = 64'd1; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || F !== 64'd8 || status !== 4'b0000)
        stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_hold: got unstable vld=%b rdy=%b F=%h, want 1 0 8",
               out_valid, in_ready, F);
    end
    in_valid = 1'b0;
    consume();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || F !== 64'd8) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_release: got rdy=%b vld=%b F=%h, want 1 0 8",
               in_ready, out_valid, F);
    end
  endtask

  task automatic test_back_to_back();
    A = 64'd10; B = 64'd20; FS = 5'b01000; CO = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    A = 64'd1; B = 64'd2;
    tests_run++;
    if (out_valid !== 1'b1 || F !== 64'd30) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got vld=%b F=%h, want 1 1e", out_valid, F);
    end
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || F !== 64'd30) begin
      tests_failed++;
      $display("[TB] FAIL b2b_gap: got vld=%b rdy=%b F=%h, want 0 1 1e", out_valid, in_ready, F);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || F !== 64'd3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got vld=%b F=%h, want 1 3", out_valid, F);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    A = 64'd1; B = 64'd63; FS = 5'b10000; CO = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || F !== 64'd0 || status !== 4'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_shift: got vld=%b F=%h st=%b rdy=%b, want 0 0 0 1",
               out_valid, F, status, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_op("add_after_reset", 64'd5, 64'd3, 5'b01000, 1'b0, 64'd8, 4'b0000, 1);
  endtask

  initial begin
    in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; FS = '0; CO = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_shift_step8();
    test_undef();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
